// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point datapath constants and shift-scheduler state type.
package fp_pkg;
    localparam int W = 48;
    localparam int SW = 8;
    localparam int STEP = 15;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} shsched_state_t;
endpackage

// File: rtl/shifter.sv
// shifter: combinational logical right shifter, zero-filled from the MSB.
module shifter #(
    parameter int W = 48
) (
    input  logic [W-1:0] din,
    input  logic [4:0]   amt,
    output logic [W-1:0] dout
);
    assign dout = din >> amt;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin two-client arbiter that runs the shared right shifter
// over multiple passes and returns the result with a sticky bit.
module shift_sched
    import fp_pkg::*;
#(
    parameter int W = fp_pkg::W,
    parameter int SW = fp_pkg::SW,
    parameter int STEP = fp_pkg::STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*W-1:0]  req_data,
    input  logic [2*SW-1:0] req_shift,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [W-1:0]    resp_data,
    output logic            resp_sticky,
    output logic            resp_id
);
    shsched_state_t state_q, state_d;
    logic [W-1:0]  acc_q, acc_d, shf_out, sel_data, mask;
    logic [SW-1:0] rem_q, rem_d, sel_shift;
    logic          sticky_q, sticky_d, id_q, id_d, rr_q, rr_d, g, big;
    logic [3:0]    k;

    shifter #(.W(W)) u_shifter (.din(acc_q), .amt({1'b0, k}), .dout(shf_out));

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        rem_d = rem_q;
        sticky_d = sticky_q;
        id_d = id_q;
        rr_d = rr_q;
        g = req_valid[rr_q] ? rr_q : ~rr_q;
        req_ready = (state_q == IDLE && !rst && req_valid[g]) ? (g ? 2'b10 : 2'b01) : 2'b00;
        sel_data = g ? req_data[2*W-1:W] : req_data[W-1:0];
        sel_shift = g ? req_shift[2*SW-1:SW] : req_shift[SW-1:0];
        big = sel_shift >= SW'(W);
        k = (rem_q > SW'(STEP)) ? 4'(STEP) : rem_q[3:0];
        mask = (W'(1) << k) - W'(1);
        case (state_q)
            IDLE: if (|req_ready) begin
                id_d = g;
                rr_d = ~g;
                acc_d = big ? '0 : sel_data;
                sticky_d = big & |sel_data;
                rem_d = big ? '0 : sel_shift;
                state_d = (big || sel_shift == '0) ? RESP : SHIFT;
            end
            SHIFT: begin
                acc_d = shf_out;
                sticky_d = sticky_q | |(acc_q & mask);
                rem_d = rem_q - SW'(k);
                state_d = (rem_q == SW'(k)) ? RESP : SHIFT;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            rem_q <= '0;
            sticky_q <= 1'b0;
            id_q <= 1'b0;
            rr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            sticky_q <= sticky_d;
            id_q <= id_d;
            rr_q <= rr_d;
        end
    end

    assign resp_valid = state_q == RESP;
    assign resp_data = acc_q;
    assign resp_sticky = sticky_q;
    assign resp_id = id_q;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed self-checking bench for shift_sched.
module tb_shift_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [95:0] req_data = '0;
    logic [15:0] req_shift = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [47:0] resp_data;
    logic        resp_sticky;
    logic        resp_id;
    int total = 0;
    int bad = 0;

    shift_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_sticky(resp_sticky),
        .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    // Presents a request from client c, drops it after the handshake and
    // returns the number of cycles until resp_valid (-1 on timeout).
    task automatic issue(input int c, input logic [47:0] d, input logic [7:0] s, output int lat);
        int n = 0;
        req_data[c*48 +: 48] = d;
        req_shift[c*8 +: 8] = s;
        req_valid[c] = 1'b1;
        #1;
        while (!req_ready[c] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!req_ready[c]) begin
            $display("FAIL grant: client %0d req_ready=%b required grant", c, req_ready);
            bad++;
        end
        @(negedge clk);
        req_valid[c] = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        total++;
        if ({resp_valid, resp_data, resp_sticky, resp_id, req_ready} !== 53'd0) begin
            $display("FAIL reset_outputs: got v=%b d=%h s=%b id=%b rdy=%b required all 0",
                     resp_valid, resp_data, resp_sticky, resp_id, req_ready);
            bad++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL reset_rr: req_ready=%b required 01", req_ready);
            bad++;
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_shift(input string name, input int c, input logic [47:0] d,
                              input logic [7:0] s, input logic [47:0] exp_d,
                              input logic exp_s, input int exp_lat);
        int lat;
        issue(c, d, s, lat);
        total++;
        if (lat !== exp_lat || resp_data !== exp_d || resp_sticky !== exp_s || resp_id !== c[0]) begin
            $display("FAIL %s: lat=%0d d=%h s=%b id=%b required lat=%0d d=%h s=%b id=%0d",
                     name, lat, resp_data, resp_sticky, resp_id, exp_lat, exp_d, exp_s, c);
            bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_contention;
        int ids[$];
        int n = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_data = {48'd4, 48'd2};
        req_shift = {8'd1, 8'd1};
        req_valid = 2'b11;
        while (ids.size() < 4 && n < 60) begin
            @(negedge clk);
            n++;
            total++;
            if (req_ready === 2'b11 || (resp_valid && req_ready !== 2'b00)) begin
                $display("FAIL contention_ready: req_ready=%b resp_valid=%b", req_ready, resp_valid);
                bad++;
            end
            if (resp_valid) begin
                total++;
                if (resp_id !== ids.size() % 2 || resp_data !== (resp_id ? 48'd2 : 48'd1)) begin
                    $display("FAIL contention_order: grant %0d id=%b d=%h required id=%0d",
                             ids.size(), resp_id, resp_data, ids.size() % 2);
                    bad++;
                end
                ids.push_back(resp_id);
            end
        end
        req_valid = 2'b00;
        total++;
        if (ids.size() != 4) begin
            $display("FAIL contention_count: got %0d responses required 4", ids.size());
            bad++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat;
        resp_ready = 1'b0;
        issue(0, 48'hF0, 8'd4, lat);
        total++;
        if (lat !== 2 || resp_data !== 48'hF || resp_sticky !== 1'b0) begin
            $display("FAIL bp_first: lat=%0d d=%h s=%b required lat=2 d=f s=0", lat, resp_data, resp_sticky);
            bad++;
        end
        req_data[95:48] = 48'h1;
        req_shift[15:8] = 8'd0;
        req_valid[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (!resp_valid || resp_data !== 48'hF || resp_sticky !== 1'b0 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
                $display("FAIL bp_hold: v=%b d=%h s=%b id=%b rdy=%b required v=1 d=f s=0 id=0 rdy=00",
                         resp_valid, resp_data, resp_sticky, resp_id, req_ready);
                bad++;
            end
        end
        resp_ready = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL bp_release: resp_valid=%b required 0", resp_valid);
            bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat = 1;
        req_data[95:48] = 48'h8000_0000_0000;
        req_shift[15:8] = 8'd40;
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            $display("FAIL mid_grant: req_ready=%b required 10", req_ready);
            bad++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_data[47:0] = 48'h0;
        req_shift[7:0] = 8'd0;
        req_valid = 2'b11;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin
            $display("FAIL mid_reset: resp_valid=%b req_ready=%b required 0 00", resp_valid, req_ready);
            bad++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            $display("FAIL mid_rr: req_ready=%b required 01", req_ready);
            bad++;
        end
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            $display("FAIL mid_regrant: req_ready=%b required 10", req_ready);
            bad++;
        end
        @(negedge clk);
        req_valid = 2'b00;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (!resp_valid || lat !== 4 || resp_data !== 48'h80 || resp_sticky !== 1'b0 || resp_id !== 1'b1) begin
            $display("FAIL mid_result: v=%b lat=%0d d=%h s=%b id=%b required v=1 lat=4 d=80 s=0 id=1",
                     resp_valid, lat, resp_data, resp_sticky, resp_id);
            bad++;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shift("short_shift", 0, 48'h0000_0000_FFFF, 8'd4, 48'h0000_0000_0FFF, 1'b1, 2);
        test_shift("multi_pass", 1, 48'h8000_0000_0000, 8'd40, 48'h0000_0000_0080, 1'b0, 4);
        test_shift("shift_0", 0, 48'h1234, 8'd0, 48'h1234, 1'b0, 1);
        test_shift("shift_48", 1, 48'h1, 8'd48, 48'h0, 1'b1, 1);
        test_shift("shift_255", 0, 48'h0, 8'd255, 48'h0, 1'b0, 1);
        test_shift("shift_47", 1, 48'hFFFF_FFFF_FFFF, 8'd47, 48'h1, 1'b1, 5);
        test_shift("shift_15", 0, 48'h8000, 8'd15, 48'h1, 1'b0, 2);
        test_shift("shift_16", 1, 48'h1_8000, 8'd16, 48'h1, 1'b1, 3);
        test_contention();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
